alu_mul_sequencer: RTL
======================

# alu_mul_sequencer

Multi-cycle controller that drives the 8-bit registered ALU's FunSel/operand inputs to compute an unsigned 8×8→16 multiply by shift-add. It owns the issuing side of the ALU interface: it sequences ADD/LSR/CSR operations, uses the ALU's internal C flag as the carry chain, and captures OutALU into local partial-product registers. It sits beside the ALU in the datapath and presents a start/busy/done handshake to the control unit.

## Interface
- Parameters: none; widths fixed at 8-bit operands and 16-bit product.
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request; sampled only in IDLE
- mcand  in  8  multiplicand; captured on accepted start
- mplier  in  8  multiplier; captured on accepted start
- busy  out  1  high from the accepting edge until DONE is left
- done  out  1  one-cycle pulse; product valid
- product  out  16  result; held until the next accepted start
- zero  out  1  product == 0; valid with done, held with product
- alu_funsel  out  4  to ALU FunSel; registered
- alu_a  out  8  to ALU A; registered
- alu_b  out  8  to ALU B; registered
- alu_out  in  8  from ALU OutALU

## Operation
- Local registers: hi[7:0], lo[7:0], mc[7:0], cnt[2:0], state.
- Accept: IDLE and start=1 at an edge → mc=mcand, lo=mplier, hi=0, cnt=0, busy=1, enter ADD.
- ALU codes used: 0000 pass-A (preserves C), 0100 add, 1100 LSR, 1111 CSR.
- Every ALU op is a 2-cycle pair:
  - OP cycle: drive the code and operands.
  - HOLD cycle: drive 0000 with the same alu_a. The ALU executes every edge, so HOLD keeps C intact.
  - Capture alu_out at the edge ending HOLD. This is the value the ALU registered at the end of OP.
- Per iteration (bit = lo[0]):
  - ADD: code 0100, a=hi, b = bit ? mc : 0. Capture into hi; C = add carry-out (cleared when b=0).
  - SHH: code 1111, a=hi. Capture into hi; C = old hi[0].
  - SHL: code 1111, a=lo. Capture into lo.
  - cnt+1. If cnt was 7, go to DONE; otherwise go to ADD.
- After 8 iterations, {hi,lo} = mc×mplier (exact; {C,hi,lo} never exceeds 17 bits).
- DONE (1 cycle): product={hi,lo}, zero=(product==0), done=1. At the next edge, go to IDLE with busy=0.
- Start while busy: ignored, no effect. Start held high in DONE is not accepted until IDLE.
- Idle/reset drive: alu_funsel=0000, alu_a=0, alu_b=0.
- The ALU has no reset. Each multiply's first carry-using op (ADD, or LSR with skip) defines C, so results do not depend on prior ALU state.

## Timing
- Reset values:
  - state=IDLE, busy=0, done=0, product=0, zero=0.
  - alu_funsel=0, alu_a=0, alu_b=0.
  - hi=lo=mc=0, cnt=0.
- Reset mid-operation: abort immediately. Product is restored to 0, not the previous result.
- Latency, base build: accept edge E0; done high in cycle 49 after E0 (48 op cycles + DONE). Next start accepted at edge E0+50 at the earliest.
- Outputs alu_* change only on clock edges; no combinational path from alu_out to any output.

## Configuration
- MULSEQ_SKIP_ZERO_EN defined: when bit=0, ADD is skipped. SHH uses code 1100 (LSR, shifts in 0, C = hi[0]) instead of 1111.
  - Cost: 4 cycles per zero bit, 6 per one bit.
  - Latency: 48 − 2×(zeros in mplier) op cycles + DONE.
- Undefined: fixed 48-cycle schedule; bit=0 issues ADD with b=0.

## Test plan
- 13×11 after reset → done exactly 49 cycles after accept, product=0x008F, zero=0, busy falls after done.
- 255×255 → product=0xFE01. The carry chain is exercised on every iteration.
- 0×0x37 → product=0x0000, zero=1. Then 0x80×0x02 → product=0x0100.
- Pulse start twice mid-operation with other operands → ignored; first result 7×9=0x003F unchanged.
- Assert rst at cycle 20 of a multiply → all outputs are their reset values at once. Then 5×6 → 0x001E with correct timing.
- Skip build only: mplier=0x01, mcand=0xFF → product=0x00FF, done 35 cycles after accept. Base build: 49.

Source files
------------

// File: rtl/alu_mul_sequencer.sv
// Shift-add 8x8->16 multiply sequencer that issues ops to an external registered ALU.
// Define MULSEQ_SKIP_ZERO_EN to skip the ADD pair on zero multiplier bits.
module alu_mul_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  mcand,
  input  logic [7:0]  mplier,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic        zero,
  output logic [3:0]  alu_funsel,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_out
);

  localparam logic [3:0] FS_PASS = 4'b0000;
  localparam logic [3:0] FS_ADD  = 4'b0100;
  localparam logic [3:0] FS_LSR  = 4'b1100;
  localparam logic [3:0] FS_CSR  = 4'b1111;

`ifdef MULSEQ_SKIP_ZERO_EN
  localparam bit SKIP_ZERO = 1'b1;
`else
  localparam bit SKIP_ZERO = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_ADD_OP, S_ADD_HOLD, S_SHH_OP, S_SHH_HOLD, S_SHL_OP, S_SHL_HOLD, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  hi_q, hi_d, lo_q, lo_d, mc_q, mc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] product_q, product_d;
  logic        zero_q, zero_d;
  logic [3:0]  alu_funsel_q, alu_funsel_d;
  logic [7:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      hi_q         <= '0;
      lo_q         <= '0;
      mc_q         <= '0;
      cnt_q        <= '0;
      product_q    <= '0;
      zero_q       <= 1'b0;
      alu_funsel_q <= FS_PASS;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      mc_q         <= mc_d;
      cnt_q        <= cnt_d;
      product_q    <= product_d;
      zero_q       <= zero_d;
      alu_funsel_q <= alu_funsel_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
    end
  end

  // Each HOLD-ending edge captures the ALU result of the preceding OP cycle.
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mc_d      = mc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    zero_d    = zero_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mc_d    = mcand;
          lo_d    = mplier;
          hi_d    = '0;
          cnt_d   = '0;
          state_d = (SKIP_ZERO && !mplier[0]) ? S_SHH_OP : S_ADD_OP;
        end
      end
      S_ADD_OP:   state_d = S_ADD_HOLD;
      S_ADD_HOLD: begin
        hi_d    = alu_out;
        state_d = S_SHH_OP;
      end
      S_SHH_OP:   state_d = S_SHH_HOLD;
      S_SHH_HOLD: begin
        hi_d    = alu_out;
        state_d = S_SHL_OP;
      end
      S_SHL_OP:   state_d = S_SHL_HOLD;
      S_SHL_HOLD: begin
        lo_d  = alu_out;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          product_d = {hi_q, alu_out};
          zero_d    = ({hi_q, alu_out} == 16'h0000);
          state_d   = S_DONE;
        end else begin
          state_d = (SKIP_ZERO && !alu_out[0]) ? S_SHH_OP : S_ADD_OP;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ALU drive is registered from the next state so it lines up with the OP/HOLD cycle.
  always_comb begin
    alu_funsel_d = FS_PASS;
    alu_a_d      = '0;
    alu_b_d      = '0;
    case (state_d)
      S_ADD_OP: begin
        alu_funsel_d = FS_ADD;
        alu_a_d      = hi_d;
        alu_b_d      = lo_d[0] ? mc_d : 8'h00;
      end
      S_SHH_OP: begin
        alu_funsel_d = (SKIP_ZERO && !lo_d[0]) ? FS_LSR : FS_CSR;
        alu_a_d      = hi_d;
      end
      S_SHL_OP: begin
        alu_funsel_d = FS_CSR;
        alu_a_d      = lo_d;
      end
      S_ADD_HOLD, S_SHH_HOLD, S_SHL_HOLD: begin
        alu_a_d = alu_a_q;
        alu_b_d = alu_b_q;
      end
      default: ;
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign product    = product_q;
  assign zero       = zero_q;
  assign alu_funsel = alu_funsel_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;

endmodule
